// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter: round-robin arbiter sharing one TinyALU among NUM_REQ requesters
//
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready    per-requester request and one-hot accept strobe (combinational in IDLE)
//   req_a/req_b/req_op     packed per-requester operands (8b) and opcode (3b), slice i = requester i
//   rsp_valid              one-cycle one-hot response pulse to the granted requester
//   rsp_result/rsp_err     16b result and error flag, valid with rsp_valid
//   grant_id               index of current/last granted requester
//   busy                   high in every state except IDLE
//   alu_a/alu_b/alu_op     operands and opcode towards tinyalu
//   alu_start              start towards tinyalu, held until done
//   alu_done/alu_result    completion and result from tinyalu
//
// Build option: define TINYALU_ARB_TIMEOUT_EN to abort a WAIT that sees no alu_done
// within TIMEOUT cycles (response err=1, result 0).
module tinyalu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [15:0]          rsp_result,
  output logic                 rsp_err,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_NOP  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [7:0]    a_q, a_d, b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic [15:0]   res_q, res_d;
  logic          err_q, err_d;
  logic [GW-1:0] win, cand;
  logic          found;
  logic [2:0]    win_op;
`ifdef TINYALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif
  // Scan from ptr+1 upwards with wrap; the nearest valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end
  assign win_op     = req_op[3*int'(win) +: 3];
  assign req_ready  = (state_q == S_IDLE && found) ? NUM_REQ'(1) << win : '0;
  assign rsp_valid  = (state_q == S_RESP) ? NUM_REQ'(1) << grant_q : '0;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign grant_id   = grant_q;
  assign busy       = state_q != S_IDLE;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  // NOP also pulses start: tinyalu expects a start for no_op but never answers it.
  assign alu_start  = state_q == S_WAIT || state_q == S_NOP;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
`ifdef TINYALU_ARB_TIMEOUT_EN
    cnt_d   = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          ptr_d   = win;
          grant_d = win;
          a_d     = req_a[8*int'(win) +: 8];
          b_d     = req_b[8*int'(win) +: 8];
          op_d    = win_op;
          res_d   = '0;
          err_d   = win_op > 3'd4;
          state_d = (win_op == 3'd0) ? S_NOP : (win_op > 3'd4) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (alu_done) begin
          res_d   = alu_result;
          state_d = S_RESP;
        end
`ifdef TINYALU_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
`endif
      end
      S_NOP:   state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= GW'(NUM_REQ - 1);
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end
`ifdef TINYALU_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb_tinyalu_arbiter: table-driven and randomized self-checking bench for tinyalu_arbiter
module tb_tinyalu_arbiter;
  localparam int N = 4;
  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid, req_ready, rsp_valid;
  logic [8*N-1:0] req_a, req_b;
  logic [3*N-1:0] req_op;
  logic [15:0]    rsp_result, alu_result;
  logic           rsp_err, busy, alu_start, alu_done;
  logic [1:0]     grant_id;
  logic [7:0]     alu_a, alu_b;
  logic [2:0]     alu_op;
  int checks = 0;
  int errors = 0;
  int ptr = N - 1;
  always #5 clk = ~clk;
  tinyalu_arbiter #(.NUM_REQ(N), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .grant_id(grant_id), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result)
  );
  typedef struct {
    int          req;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    int          lat;
    logic [15:0] res;
    logic        err;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  function automatic logic [15:0] ref_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction
  function automatic int pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction
  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_op[3*i +: 3] = op;
    req_valid[i] = 1'b1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0;
    alu_done = 1'b0;
    alu_result = '0;
    tick();
    tick();
    reset_n = 1'b1;
    ptr = N - 1;
  endtask
  // Acts as the requesters and as tinyalu for one full transaction.
  task automatic service_one(input int lat, output int w, output logic [15:0] res, output logic err);
    int t;
    logic [2:0] op;
    logic [7:0] a, b;
    w = -1;
    res = '0;
    err = 1'b0;
    t = 0;
    #1;
    while (req_ready == '0 && t < 20) begin
      tick();
      t++;
    end
    if (req_ready == '0) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    w = pick(req_valid);
    chk("req_ready", 32'(req_ready), 32'(1) << w);
    a = req_a[8*w +: 8];
    b = req_b[8*w +: 8];
    op = req_op[3*w +: 3];
    ptr = w;
    tick();
    req_valid[w] = 1'b0;
    chk("grant_id", 32'(grant_id), 32'(w));
    chk("busy_after_accept", 32'(busy), 1);
    if (op >= 3'd1 && op <= 3'd4) begin
      chk("alu_start", 32'(alu_start), 1);
      chk("alu_op", 32'(alu_op), 32'(op));
      chk("alu_a", 32'(alu_a), 32'(a));
      chk("alu_b", 32'(alu_b), 32'(b));
      repeat (lat) begin
        tick();
        chk("start_held", 32'(alu_start), 1);
      end
      alu_done = 1'b1;
      alu_result = ref_res(alu_op, alu_a, alu_b);
      tick();
      alu_done = 1'b0;
      alu_result = 16'($urandom);
    end else if (op == 3'd0) begin
      chk("nop_start", 32'(alu_start), 1);
      tick();
    end else begin
      chk("illegal_no_start", 32'(alu_start), 0);
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(1) << w);
    chk("start_off_in_rsp", 32'(alu_start), 0);
    chk("rsp_result", 32'(rsp_result), 32'(ref_res(op, a, b)));
    chk("rsp_err", 32'(rsp_err), 32'(op > 3'd4));
    res = rsp_result;
    err = rsp_err;
    tick();
    chk("idle_after_rsp", 32'(busy), 0);
    chk("rsp_pulse_once", 32'(rsp_valid), 0);
  endtask
  initial begin
    int w, cnt;
    logic [15:0] r;
    logic e;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    alu_done = 1'b0;
    alu_result = '0;
    tbl[0] = '{0, 8'hFF, 8'h01, 3'd1, 2, 16'h0100, 1'b0};
    tbl[1] = '{2, 8'h12, 8'h34, 3'd7, 0, 16'h0000, 1'b1};
    tbl[2] = '{1, 8'h56, 8'h78, 3'd0, 0, 16'h0000, 1'b0};
    tbl[3] = '{3, 8'hF0, 8'h3C, 3'd2, 1, 16'h0030, 1'b0};
    tbl[4] = '{1, 8'hAA, 8'h55, 3'd3, 0, 16'h00FF, 1'b0};
    tbl[5] = '{2, 8'hFF, 8'hFF, 3'd4, 4, 16'hFE01, 1'b0};
    tbl[6] = '{0, 8'h80, 8'h80, 3'd5, 0, 16'h0000, 1'b1};
    do_reset();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(alu_start), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_result", 32'(rsp_result), 0);
    chk("rst_alu_ab", 32'({alu_a, alu_b, 5'd0, alu_op}), 0);
    for (int i = 0; i < 7; i++) begin
      set_req(tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].op);
      service_one(tbl[i].lat, w, r, e);
      chk("tbl_winner", 32'(w), 32'(tbl[i].req));
      chk("tbl_result", 32'(r), 32'(tbl[i].res));
      chk("tbl_err", 32'(e), 32'(tbl[i].err));
    end
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'h10, 8'h10, 3'd4);
    for (int k = 0; k < N; k++) begin
      service_one(1, w, r, e);
      chk("rr_order", 32'(w), 32'(k));
      chk("rr_mul", 32'(r), 32'h0100);
    end
    for (int i = 0; i < N; i++) set_req(i, 8'h10, 8'h10, 3'd4);
    service_one(0, w, r, e);
    chk("rr_wrap", 32'(w), 0);
    for (int k = 1; k < N; k++) service_one(0, w, r, e);
    alu_done = 1'b1;
    alu_result = 16'hBEEF;
    tick();
    alu_done = 1'b0;
    chk("done_in_idle_busy", 32'(busy), 0);
    chk("done_in_idle_rsp", 32'(rsp_valid), 0);
    set_req(0, 8'h10, 8'h10, 3'd4);
    #1;
    chk("mid_ready", 32'(req_ready), 1);
    tick();
    req_valid = '0;
    chk("mid_wait_start", 32'(alu_start), 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_start", 32'(alu_start), 0);
    chk("async_rst_busy", 32'(busy), 0);
    tick();
    chk("async_rst_rsp", 32'(rsp_valid), 0);
    reset_n = 1'b1;
    ptr = N - 1;
    tick();
    chk("no_rsp_after_rst", 32'(rsp_valid), 0);
    set_req(3, 8'h01, 8'h02, 3'd1);
    set_req(0, 8'h03, 8'h04, 3'd1);
    service_one(0, w, r, e);
    chk("post_rst_grant", 32'(w), 0);
    service_one(0, w, r, e);
    chk("post_rst_grant2", 32'(w), 3);
    set_req(1, 8'h03, 8'h04, 3'd1);
    tick();
    req_valid = '0;
`ifdef TINYALU_ARB_TIMEOUT_EN
    cnt = 0;
    while (alu_start && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("timeout_cycles", 32'(cnt), 15);
    chk("timeout_rsp_valid", 32'(rsp_valid), 32'b0010);
    chk("timeout_err", 32'(rsp_err), 1);
    chk("timeout_result", 32'(rsp_result), 0);
    tick();
`else
    cnt = 0;
    repeat (100) tick();
    chk("no_timeout_busy", 32'(busy), 1);
    chk("no_timeout_start", 32'(alu_start), 1);
    alu_done = 1'b1;
    alu_result = ref_res(alu_op, alu_a, alu_b);
    tick();
    alu_done = 1'b0;
    chk("late_done_rsp", 32'(rsp_valid), 32'b0010);
    chk("late_done_result", 32'(rsp_result), 32'h0007);
    chk("late_done_err", 32'(rsp_err), 0);
    tick();
`endif
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      if (req_valid == '0) set_req(int'($urandom_range(0, N - 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      service_one(int'($urandom_range(0, 4)), w, r, e);
    end
    cnt = 0;
    while (req_valid != '0 && cnt < 10) begin
      service_one(0, w, r, e);
      cnt++;
    end
    chk("drained", 32'(req_valid), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
